// File: rtl/sd_write_buffer.sv
// sd_write_buffer: collects one 512-byte sector as 128 big-endian 32-bit
// words, presents it bit-ordered for LSB-first shifting to the SD write
// engine, and reports completion or error.
// Optional write-completion watchdog: define SD_WBUF_TIMEOUT_EN.

module sd_write_buffer #(
    parameter int TIMEOUT_W = 24
) (
    input  logic          sdclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [31:0]   sector,
    input  logic          word_valid,
    input  logic [31:0]   word_data,
    output logic          word_ready,
    output logic [31:0]   sd_addr,
    output logic [4095:0] sd_wdata,
    output logic          sd_we,
    input  logic          sd_wend,
    input  logic          sd_werr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        RELEASE,
        DONE,
        ERROR
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] word_cnt;
    logic       word_xfer;
    logic       timeout_hit;

    // Byte j, bit b of a word lands at slot bit j*8 + (7-b); across the
    // whole word that is a plain 32-bit reversal.
    function automatic logic [31:0] bit_reverse(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[31 - i];
        end
        return r;
    endfunction

    assign word_xfer = word_valid && word_ready;

`ifdef SD_WBUF_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] timeout_cnt;

    // Watchdog counts ISSUE cycles; held at zero in every other state.
    always_ff @(posedge sdclk) begin
        if (!reset_n) begin
            timeout_cnt <= '0;
        end else if (state != ISSUE) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Fire as the counter steps onto all-ones, i.e. after 2^W-1 ISSUE cycles.
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout_w;

    assign timeout_hit      = 1'b0;
    assign unused_timeout_w = |TIMEOUT_W;
`endif

    // State register.
    always_ff @(posedge sdclk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; error takes priority over completion.
    always_comb begin
        next_state = state;
        word_ready = 1'b0;
        sd_we      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                word_ready = 1'b1;
                if (word_valid && (word_cnt == 7'd127)) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                sd_we = 1'b1;
                if (sd_werr) begin
                    next_state = ERROR;
                end else if (sd_wend) begin
                    next_state = RELEASE;
                end else if (timeout_hit) begin
                    next_state = ERROR;
                end
            end
            RELEASE: begin
                if (!sd_wend) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sector address capture, word counter and sector image assembly.
    always_ff @(posedge sdclk) begin
        if (!reset_n) begin
            word_cnt <= '0;
            sd_addr  <= '0;
            sd_wdata <= '1;
        end else begin
            if ((state == IDLE) && start) begin
                sd_addr  <= sector;
                word_cnt <= '0;
            end
            if (word_xfer) begin
                sd_wdata[{word_cnt, 5'd0} +: 32] <= bit_reverse(word_data);
                if (word_cnt != 7'd127) begin
                    word_cnt <= word_cnt + 7'd1;
                end
            end
        end
    end

endmodule
